sat_cmd_sequencer: RTL and testbench

Parametrised command sequencer that stores a SAT-accelerator command program and streams it into `SAT_accelerator_top` over a valid/ready handshake. It replaces the fixed, free-running command buffer with a writable program memory, a programmable length, backpressure, one-shot or looping playback, and abort. It sits between the host/bench load port and the accelerator `command` input.

---
 rtl/sat_pkg.sv | 30 +++
 rtl/sat_cmd_mem.sv | 25 ++
 rtl/sat_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sat_cmd_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types and command-field helpers for the SAT command sequencer.
package sat_pkg;

  typedef enum logic [1:0] {
    OP_RESET  = 2'b00,
    OP_CLAUSE = 2'b01,
    OP_CNF    = 2'b10,
    OP_CLR    = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned OPC_W   = 2;
  localparam int unsigned NEG_POS = 0;
  localparam int unsigned VAR_LSB = 1;

  // Field positions depend on the command width, so they are derived here.
  function automatic int unsigned opc_lsb(input int unsigned cmd_w);
    return cmd_w - OPC_W;
  endfunction

  function automatic int unsigned var_msb(input int unsigned cmd_w);
    return cmd_w - OPC_W - 1;
  endfunction

endpackage

// File: rtl/sat_cmd_mem.sv
// Command program register file: synchronous write, asynchronous read, no reset.
module sat_cmd_mem #(
  parameter int unsigned CMD_W  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CMD_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CMD_W-1:0]  rd_data
);

  logic [CMD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sat_cmd_sequencer.sv
// Writable command program streamed to the SAT accelerator over valid/ready.
// Optional handshake statistics outputs are enabled by SAT_CMD_STATS_EN.
module sat_cmd_sequencer
  import sat_pkg::*;
#(
  parameter int unsigned CMD_W  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CMD_W-1:0]  wr_data,
  output logic              wr_err,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [CMD_W-1:0]  cmd_out,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
`ifdef SAT_CMD_STATS_EN
  ,
  output logic [15:0]       issue_cnt,
  output logic [15:0]       cnf_cnt
`endif
);

  state_e            state;
  logic [ADDR_W:0]   len;
  logic              loop;
  logic [ADDR_W:0]   len_sel;
  logic              last;
  logic              hs;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [CMD_W-1:0]  rd_data;

  assign len_sel = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;
  assign last    = ({1'b0, pc} == (len - 1'b1));
  assign hs      = cmd_valid && cmd_ready;
  assign mem_we  = wr_en && (state != ST_RUN);

  // Read address is the pc the next handshake would move to; entry 0 otherwise,
  // which also serves start and loop wrap without a bubble.
  always_comb begin
    rd_addr = '0;
    if (state == ST_RUN && !last) begin
      rd_addr = pc + 1'b1;
    end
  end

  sat_cmd_mem #(
    .CMD_W  (CMD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      len       <= '0;
      loop      <= 1'b0;
      pc        <= '0;
      cmd_out   <= '0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_en && (state == ST_RUN);
      if (stop) begin
        state     <= ST_IDLE;
        pc        <= '0;
        cmd_out   <= '0;
        cmd_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              len  <= len_sel;
              loop <= loop_en;
              if (len_sel == '0) begin
                state     <= ST_DONE;
                cmd_out   <= '0;
                cmd_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                state     <= ST_RUN;
                pc        <= '0;
                cmd_out   <= rd_data;
                cmd_valid <= 1'b1;
                busy      <= 1'b1;
                done      <= 1'b0;
              end
            end
          end
          ST_RUN: begin
            if (hs) begin
              if (!last) begin
                pc      <= pc + 1'b1;
                cmd_out <= rd_data;
              end else if (loop) begin
                pc      <= '0;
                cmd_out <= rd_data;
              end else begin
                state     <= ST_DONE;
                cmd_out   <= '0;
                cmd_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
          default: begin
            state     <= ST_IDLE;
            cmd_out   <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SAT_CMD_STATS_EN
  localparam int unsigned OPC_LSB = opc_lsb(CMD_W);

  logic is_cnf;
  assign is_cnf = (cmd_out[OPC_LSB +: OPC_W] == OP_CNF);

  // A handshake overridden by stop is not counted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      issue_cnt <= '0;
      cnf_cnt   <= '0;
    end else if (!stop) begin
      if (state != ST_RUN && start) begin
        issue_cnt <= '0;
        cnf_cnt   <= '0;
      end else if (state == ST_RUN && hs) begin
        if (issue_cnt != '1) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (is_cnf && cnf_cnt != '1) begin
          cnf_cnt <= cnf_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sat_cmd_sequencer.sv
// Self-checking bench for sat_cmd_sequencer: vector table, corner sequences, random vs. queue model.
module tb_sat_cmd_sequencer;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_err;
  logic [4:0] prog_len = '0;
  logic       loop_en = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cmd_out;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [3:0] pc;
  logic       busy;
  logic       done;
`ifdef SAT_CMD_STATS_EN
  logic [15:0] issue_cnt;
  logic [15:0] cnf_cnt;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sat_cmd_sequencer #(.CMD_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .prog_len  (prog_len),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
`ifdef SAT_CMD_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .cnf_cnt   (cnf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [4:0] pl, input logic le, input logic st,
                       input logic sp, input logic rd);
    wr_en = we; wr_addr = wa; wr_data = wd; prog_len = pl;
    loop_en = le; start = st; stop = sp; cmd_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'd0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [4:0] pl;
    logic       le, st, sp, rd;
    logic       e_valid;
    logic [7:0] e_out;
    logic [3:0] e_pc;
    logic       e_busy, e_done, e_err;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic [4:0] pl, input logic st, input logic sp,
                              input logic rd, input logic ev, input logic [7:0] eo,
                              input logic [3:0] ep, input logic eb, input logic ed,
                              input logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.pl = pl; v.le = 1'b0; v.st = st; v.sp = sp;
    v.rd = rd; v.e_valid = ev; v.e_out = eo; v.e_pc = ep; v.e_busy = eb;
    v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [$];

  // Queue-based reference model for the random phase.
  logic [7:0] m_mem [16];
  int         q [$];
  int         m_len;
  logic       m_loop, m_active, m_done, m_err;
  logic [7:0] m_out;
  logic [3:0] m_pc;

  task automatic refill();
    for (int k = 0; k < m_len; k++) q.push_back(k);
  endtask

  task automatic rstep(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [4:0] pl, input logic le, input logic st,
                       input logic sp, input logic rd);
    logic was_active;
    drive(we, wa, wd, pl, le, st, sp, rd);
    @(posedge clk);
    was_active = m_active;
    m_err = we && was_active;
    if (sp) begin
      m_active = 1'b0; m_done = 1'b0; q.delete(); m_out = '0; m_pc = '0;
    end else if (!was_active && st) begin
      m_len  = (int'(pl) > 16) ? 16 : int'(pl);
      m_loop = le;
      if (m_len == 0) begin
        m_done = 1'b1; m_out = '0;
      end else begin
        m_active = 1'b1; m_done = 1'b0; q.delete(); refill();
        m_out = m_mem[0]; m_pc = '0;
      end
    end else if (was_active && rd) begin
      q.delete(0);
      if (q.size() == 0 && m_loop) refill();
      if (q.size() == 0) begin
        m_active = 1'b0; m_done = 1'b1; m_out = '0;
      end else begin
        m_out = m_mem[q[0]]; m_pc = 4'(q[0]);
      end
    end
    if (we && !was_active) m_mem[wa] = wd;
    #1;
    chk("rnd_valid", cmd_valid, m_active);
    chk("rnd_out",   cmd_out,   m_out);
    chk("rnd_pc",    pc,        m_pc);
    chk("rnd_busy",  busy,      m_active);
    chk("rnd_done",  done,      m_done);
    chk("rnd_err",   wr_err,    m_err);
  endtask

  initial begin
    int n;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_out",   cmd_out,   0);
    chk("rst_pc",    pc,        0);
    chk("rst_busy",  busy,      0);
    chk("rst_done",  done,      0);
    chk("rst_err",   wr_err,    0);
    resetN = 1'b1;

    // we, wa, wd, pl, st, sp, rd | valid, out, pc, busy, done, err
    tbl.push_back(mk(1, 0, 8'h40, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h42, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 8'h80, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 8'hC0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 1, 0, 1,  1, 8'h40, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  1, 8'h42, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  1, 8'h80, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  1, 8'hC0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  0, 8'h00, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  0, 8'h00, 3, 0, 1, 0));
    // backpressure: ready low on cycles 2-4
    tbl.push_back(mk(0, 0, 8'h00, 4, 1, 0, 1,  1, 8'h40, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  1, 8'h42, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0,  1, 8'h42, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0,  1, 8'h42, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0,  1, 8'h42, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  1, 8'h80, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  1, 8'hC0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1,  0, 8'h00, 3, 0, 1, 0));
    // write during RUN is rejected
    tbl.push_back(mk(0, 0, 8'h00, 4, 1, 0, 0,  1, 8'h40, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFF, 4, 0, 0, 0,  1, 8'h40, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0,  1, 8'h40, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 1, 0, 1,  1, 8'h40, 0, 1, 0, 0));
    // stop beats handshake; stop beats start
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 1, 1,  0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 1, 1, 1,  0, 8'h00, 0, 0, 0, 0));
    // zero-length program
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1,  0, 8'h00, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].pl, tbl[i].le, tbl[i].st, tbl[i].sp, tbl[i].rd);
      tick();
      chk($sformatf("t%0d_valid", i), cmd_valid, tbl[i].e_valid);
      chk($sformatf("t%0d_out", i),   cmd_out,   tbl[i].e_out);
      chk($sformatf("t%0d_pc", i),    pc,        tbl[i].e_pc);
      chk($sformatf("t%0d_busy", i),  busy,      tbl[i].e_busy);
      chk($sformatf("t%0d_done", i),  done,      tbl[i].e_done);
      chk($sformatf("t%0d_err", i),   wr_err,    tbl[i].e_err);
    end

    // Loop playback of two entries, no bubble on wrap.
    drive(1, 0, 8'h41, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 8'h42, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 8'h00, 2, 1, 1, 0, 1); tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("loop%0d_valid", k), cmd_valid, 1);
      chk($sformatf("loop%0d_out", k),   cmd_out, (k % 2 == 0) ? 8'h41 : 8'h42);
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("loop_stop_valid", cmd_valid, 0);
    chk("loop_stop_busy",  busy, 0);
    chk("loop_stop_done",  done, 0);

    // Oversized length clamps to DEPTH entries.
    for (int k = 0; k < 16; k++) begin
      drive(1, 4'(k), 8'(8'h10 + k), 0, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 8'h00, 20, 0, 1, 0, 1); tick();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && cmd_valid; k++) begin
      chk($sformatf("clamp%0d_out", n), cmd_out, 8'(8'h10 + n));
      n++;
      tick();
    end
    chk("clamp_count", n, 16);
    chk("clamp_done", done, 1);

    // Asynchronous reset between edges during RUN; memory survives.
    drive(0, 0, 8'h00, 4, 0, 1, 0, 0); tick();
    start = 1'b0;
    chk("ar_busy_before", busy, 1);
    #3;
    resetN = 1'b0;
    #1;
    chk("ar_valid", cmd_valid, 0);
    chk("ar_busy",  busy, 0);
    chk("ar_done",  done, 0);
    chk("ar_out",   cmd_out, 0);
    @(negedge clk);
    resetN = 1'b1;
    drive(0, 0, 8'h00, 4, 0, 1, 0, 1); tick();
    start = 1'b0;
    chk("ar_replay_out", cmd_out, 8'h10);
    chk("ar_replay_pc",  pc, 0);
    tick();
    chk("ar_replay_out1", cmd_out, 8'h11);
    stop = 1'b1; tick(); stop = 1'b0;

    // Random phase against the queue model.
    m_active = 1'b0; m_done = 1'b0; m_out = '0; m_pc = '0; m_err = 1'b0;
    m_len = 0; m_loop = 1'b0; q.delete();
    for (int k = 0; k < 16; k++) begin
      rstep(1'b1, 4'(k), 8'($urandom), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 1500; k++) begin
      rstep(($urandom_range(0, 99) < 15), 4'($urandom), 8'($urandom),
            5'($urandom_range(0, 20)), 1'($urandom), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70));
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
